// File: rtl/fir_filter_mac.sv
// fir_filter_mac: time-multiplexed FIR filter, one shared MAC step per clock,
// with runtime-loadable coefficients, rounding and output saturation.
module fir_filter_mac #(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int TAPS = 71,
   parameter int FRAC = 15,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic                 clk,
   input  logic                 reset1,
   input  logic                 sample_valid,
   input  logic signed [DW-1:0] sample,
   output logic                 sample_ready,
   input  logic                 coeff_we,
   input  logic [AW-1:0]        coeff_addr,
   input  logic signed [CW-1:0] coeff_data,
   output logic signed [DW-1:0] result,
   output logic                 result_valid,
   output logic                 overflow
);
   localparam int ACC_W = DW + CW + AW;
   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
   localparam logic [AW:0] TAPS_X = (AW + 1)'(TAPS);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'((2 ** FRAC) >> 1);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t state, state_nx;
   logic signed [DW-1:0] dline [TAPS];
   logic signed [CW-1:0] coef [TAPS];
   logic [AW-1:0] wp, base, k, idx;
   logic [AW:0] idx_wrap;
   logic signed [DW+CW-1:0] prod;
   logic signed [ACC_W-1:0] acc, prod_x, rnd, shf, sat;
   logic accept, cw_ok;

   assign sample_ready = state == IDLE;
   assign accept = sample_valid & sample_ready;
   assign cw_ok = coeff_we & sample_ready & ({1'b0, coeff_addr} < TAPS_X);

   always_comb begin
      state_nx = state == IDLE ? (accept ? MAC : IDLE) :
                 state == MAC  ? (k == LAST ? DONE : MAC) : IDLE;
   end

   // tap k reads x[n-k], stored (base - k) mod TAPS in the circular buffer
   always_comb begin
      idx_wrap = {1'b0, base} + TAPS_X - {1'b0, k};
      idx = base >= k ? base - k : idx_wrap[AW-1:0];
      prod = (DW + CW)'(dline[idx]) * (DW + CW)'(coef[k]);
      prod_x = ACC_W'(prod);
      rnd = acc + HALF;
      shf = rnd >>> FRAC;
      sat = shf > MAXV ? MAXV : shf < MINV ? MINV : shf;
   end

   always_ff @(posedge clk or posedge reset1) begin
      if (reset1) begin
         state <= IDLE;
         wp <= '0;
         base <= '0;
         k <= '0;
         acc <= '0;
         result <= '0;
         result_valid <= 1'b0;
         overflow <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            dline[i] <= '0;
            coef[i] <= '0;
         end
      end else begin
         state <= state_nx;
         result_valid <= 1'b0;
         if (cw_ok) coef[coeff_addr] <= coeff_data;
         if (accept) begin
            dline[wp] <= sample;
            base <= wp;
            wp <= wp == LAST ? '0 : wp + 1'b1;
            k <= '0;
            acc <= '0;
         end
         if (state == MAC) begin
            acc <= acc + prod_x;
            k <= k + 1'b1;
         end
         if (state == DONE) begin
            result <= sat[DW-1:0];
            overflow <= sat != shf;
            result_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fir_filter_mac.sv
// tb_fir_filter_mac: scoreboard bench; instance a uses FRAC=0, instance b FRAC=15.
module tb_fir_filter_mac;
   logic clk = 1'b0, reset1 = 1'b1, sample_valid = 1'b0, sel_b = 1'b0, coeff_we = 1'b0;
   logic signed [15:0] sample = '0, coeff_data = '0;
   logic [1:0] coeff_addr = '0;
   logic rdy_a, rdy_b, rv_a, rv_b, ov_a, ov_b, sv_a, sv_b;
   logic signed [15:0] res_a, res_b;

   typedef struct {logic signed [15:0] r; logic o; int c;} exp_t;
   exp_t qa[$], qb[$];
   int cyc = 0, n_cmp = 0, n_bad = 0;

   assign sv_a = sample_valid & ~sel_b;
   assign sv_b = sample_valid & sel_b;

   fir_filter_mac #(.DW(16), .CW(16), .TAPS(4), .FRAC(0)) dut_a (
      .clk(clk), .reset1(reset1), .sample_valid(sv_a), .sample(sample), .sample_ready(rdy_a),
      .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
      .result(res_a), .result_valid(rv_a), .overflow(ov_a));

   fir_filter_mac #(.DW(16), .CW(16), .TAPS(4), .FRAC(15)) dut_b (
      .clk(clk), .reset1(reset1), .sample_valid(sv_b), .sample(sample), .sample_ready(rdy_b),
      .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
      .result(res_b), .result_valid(rv_b), .overflow(ov_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rv_a) begin
         if (qa.size() == 0) check("spurious result_valid a", rv_a, 0);
         else begin
            exp_t e;
            e = qa.pop_front();
            check("result a", res_a, e.r);
            check("overflow a", ov_a, e.o);
            check("latency a", cyc, e.c);
         end
      end
      if (rv_b) begin
         if (qb.size() == 0) check("spurious result_valid b", rv_b, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            check("result b", res_b, e.r);
            check("overflow b", ov_b, e.o);
            check("latency b", cyc, e.c);
         end
      end
   end

   task automatic push(input int r, input logic o);
      exp_t e;
      e.r = 16'(r);
      e.o = o;
      e.c = cyc + 6;
      if (sel_b) qb.push_back(e);
      else qa.push_back(e);
   endtask

   task automatic wcoef(input int a, input int d);
      @(negedge clk);
      coeff_we = 1'b1;
      coeff_addr = a[1:0];
      coeff_data = 16'(d);
      @(negedge clk);
      coeff_we = 1'b0;
   endtask

   task automatic load4(input int c0, input int c1, input int c2, input int c3);
      wcoef(0, c0);
      wcoef(1, c1);
      wcoef(2, c2);
      wcoef(3, c3);
   endtask

   task automatic send(input int s, input int r, input logic o);
      int n = 0;
      @(negedge clk);
      sample = 16'(s);
      sample_valid = 1'b1;
      while (!(sel_b ? rdy_b : rdy_a) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("sample_ready timeout", sel_b ? rdy_b : rdy_a, 1);
         sample_valid = 1'b0;
      end else begin
         push(r, o);
         @(posedge clk);
         #1 sample_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("pending results", qa.size() + qb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset1 = 1'b0;
   endtask

   task automatic impulse();
      send(1, 100, 1'b0);
      send(0, 200, 1'b0);
      send(0, 300, 1'b0);
      send(0, 400, 1'b0);
      send(0, 0, 1'b0);
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ramp[9] = '{1, 3, 6, 10, 14, 18, 22, 26, 30};
      int ex5[3] = '{5, 10, 15};
      int nr = 0, na = 0;
      repeat (2) @(negedge clk);
      check("reset result", res_a, 0);
      check("reset result_valid", rv_a, 0);
      check("reset overflow", ov_a, 0);
      reset1 = 1'b0;
      @(negedge clk);
      check("ready after reset a", rdy_a, 1);
      check("ready after reset b", rdy_b, 1);
      check("reset result b", res_b, 0);

      load4(100, 200, 300, 400);
      impulse();

      load4(1, 1, 1, 1);
      for (int i = 0; i < 9; i++) send(i + 1, ramp[i], 1'b0);
      drain();

      load4(32767, 0, 0, 0);
      send(2, 32767, 1'b1);
      send(-2, -32768, 1'b1);
      send(1, 32767, 1'b0);
      drain();
      check("overflow held", ov_a, 0);
      check("result held", res_a, 32767);

      load4(16384, 0, 0, 0);
      sel_b = 1'b1;
      send(3, 2, 1'b0);
      send(-3, -1, 1'b0);
      send(4, 2, 1'b0);
      drain();
      sel_b = 1'b0;

      do_reset();
      load4(1, 1, 1, 1);
      sample = 16'sd5;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         sample_valid = 1'b1;
         if (rdy_a) begin
            nr++;
            if (na < 3) push(ex5[na], 1'b0);
            na++;
         end
         if (i == 2) begin
            coeff_we = 1'b1;
            coeff_addr = 2'd0;
            coeff_data = 16'sd100;
         end
         if (i == 3) coeff_we = 1'b0;
      end
      sample_valid = 1'b0;
      check("ready cycles of 18", nr, 3);
      drain();

      do_reset();
      load4(100, 200, 300, 400);
      @(negedge clk);
      sample = 16'sd1;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset1 = 1'b1;
      @(negedge clk);
      check("mid-MAC reset result_valid", rv_a, 0);
      reset1 = 1'b0;
      repeat (8) @(negedge clk);
      check("aborted result", res_a, 0);
      check("aborted overflow", ov_a, 0);
      send(7, 0, 1'b0);
      drain();
      do_reset();
      load4(100, 200, 300, 400);
      impulse();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
